// File: rtl/restoring_divider.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// restoring_divider
//
// Sequential 4-bit unsigned restoring divider for the Basys3 board. On a start
// button press the dividend (sw[3:0]) and divisor (sw[7:4]) are latched, then a
// one-bit-per-cycle shift/subtract loop produces quotient and remainder, which
// are shown on the LEDs together with busy / divide-by-zero / done flags.
//
// Ports:
//   clk        board clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   sw[7:0]    sw[3:0] = dividend A, sw[7:4] = divisor B (unsigned)
//   btn_start  asynchronous start button, active-high
//   led[15:0]  [3:0] quotient, [7:4] remainder, [12:8] zero,
//              [13] busy, [14] dbz, [15] done
//
// Parameters:
//   DBNC_CYCLES  stable cycles required by the optional button debouncer
//
// Compile-time option:
//   RESTORING_DIVIDER_DBNC_EN  inserts a debouncer between the synchronizer
//                              and the edge detector (adds DBNC_CYCLES cycles
//                              of start latency). Undefined: no debouncer.
// -----------------------------------------------------------------------------
module restoring_divider #(
    parameter int DBNC_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  sw,
    input  logic        btn_start,
    output logic [15:0] led
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;

    // Start path: two-flop synchronizer, then a delay flop for edge detection.
    logic       s1_q, s2_q, s3_q;
    logic       start_lvl;      // synchronized (optionally debounced) level
    logic       start_pulse;

    // Datapath. The partial remainder is always below the divisor, so it is
    // stored in 4 bits; the 5th bit only exists transiently after the shift.
    logic [3:0] rem_q, rem_d;
    logic [3:0] quo_q, quo_d;
    logic [3:0] b_q, b_d;
    logic [1:0] count_q, count_d;
    logic [3:0] q_q, q_d;
    logic [3:0] r_q, r_d;
    logic       dbz_q, dbz_d;

    logic [4:0] sh_rem;
    logic [3:0] sh_quo;
    logic [4:0] trial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= btn_start;
            s2_q <= s1_q;
            s3_q <= start_lvl;
        end
    end

`ifdef RESTORING_DIVIDER_DBNC_EN
    localparam int DCW = $clog2(DBNC_CYCLES + 1);

    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic           dlvl_q, dlvl_d;

    // The level follows s2 only after s2 has disagreed with it for
    // DBNC_CYCLES consecutive cycles; any agreement restarts the count.
    always_comb begin
        dcnt_d = '0;
        dlvl_d = dlvl_q;
        if (s2_q != dlvl_q) begin
            if (dcnt_q == DCW'(DBNC_CYCLES - 1)) begin
                dlvl_d = s2_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q <= '0;
            dlvl_q <= 1'b0;
        end else begin
            dcnt_q <= dcnt_d;
            dlvl_q <= dlvl_d;
        end
    end

    assign start_lvl = dlvl_q;
`else
    // Without the debouncer the parameter has no effect.
    logic unused_dbnc;
    assign unused_dbnc = (DBNC_CYCLES > 0);

    assign start_lvl = s2_q;
`endif

    assign start_pulse = start_lvl & ~s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            b_q     <= '0;
            count_q <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            b_q     <= b_d;
            count_q <= count_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        b_d     = b_q;
        count_d = count_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        // {rem, quo} shifted left by one, then trial subtraction of the divisor.
        sh_rem  = {rem_q, quo_q[3]};
        sh_quo  = {quo_q[2:0], 1'b0};
        trial   = sh_rem - {1'b0, b_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_pulse) begin
                    b_d     = sw[7:4];
                    rem_d   = '0;
                    quo_d   = sw[3:0];
                    count_d = '0;
                    if (sw[7:4] == 4'd0) begin
                        state_d = S_DONE;
                        q_d     = 4'hF;
                        r_d     = sw[3:0];
                        dbz_d   = 1'b1;
                    end else begin
                        // Displayed result and flags stay until the new DONE.
                        state_d = S_RUN;
                        count_d = 2'd3;
                    end
                end
            end
            S_RUN: begin
                // Negative trial (borrow in bit 4) restores the shifted value.
                if (trial[4]) begin
                    rem_d = sh_rem[3:0];
                    quo_d = sh_quo;
                end else begin
                    rem_d = trial[3:0];
                    quo_d = {sh_quo[3:1], 1'b1};
                end
                if (count_q == 2'd0) begin
                    state_d = S_DONE;
                    q_d     = quo_d;
                    r_d     = rem_d;
                    dbz_d   = 1'b0;
                end else begin
                    count_d = count_q - 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign led = {(state_q == S_DONE), dbz_q, (state_q == S_RUN), 5'b00000, r_q, q_q};

endmodule
